// File: rtl/i2c_slave_mem.sv
// I2C slave exposing an 8-bit register file with pointer, auto-increment and a write-notify strobe.
// SCL/SDA are oversampled on clk through a 2-flop synchroniser and a FILT-sample glitch filter.
`timescale 1ns/1ps
module i2c_slave_mem #(
  parameter logic [6:0]  I2C_ADR   = 7'h10,
  parameter int unsigned MEM_DEPTH = 16,
  parameter int unsigned AW        = 4,
  parameter int unsigned FILT      = 3
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          busy,
  output logic          wr_stb,
  output logic [AW-1:0] wr_adr,
  output logic [7:0]    wr_dat
);

  localparam int unsigned FCW = 3;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, MADR, MADR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  // Input conditioning; index 1 = SCL, index 0 = SDA.
  logic [1:0]     sync1, sync2, filt, flip_c;
  logic [FCW-1:0] fcnt [2];

  always_comb begin
    for (int i = 0; i < 2; i++)
      flip_c[i] = (sync2[i] != filt[i]) && (fcnt[i] == FCW'(FILT - 1));
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sync1   <= '1;
      sync2   <= '1;
      filt    <= '1;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      sync1 <= {scl_i, sda_i};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (flip_c[i]) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else if (sync2[i] != filt[i]) begin
          fcnt[i] <= fcnt[i] + FCW'(1);
        end else begin
          fcnt[i] <= '0;
        end
      end
    end
  end

  logic scl_rise_c, scl_fall_c, sda_rise_c, sda_fall_c, start_c, stop_c;
  assign scl_rise_c = flip_c[1] & ~filt[1];
  assign scl_fall_c = flip_c[1] &  filt[1];
  assign sda_rise_c = flip_c[0] & ~filt[0];
  assign sda_fall_c = flip_c[0] &  filt[0];
  assign start_c    = sda_fall_c & filt[1];
  assign stop_c     = sda_rise_c & filt[1];

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic          byte_done, byte_done_n;
  logic [7:0]    shreg, shreg_n, shout, shout_n;
  logic          rw, rw_n, mack, mack_n;
  logic [AW-1:0] ptr, ptr_n, wr_adr_n;
  logic          sda_oe_n, busy_n, wr_stb_n, mem_we_c;
  logic [7:0]    wr_dat_n;
  logic [7:0]    mem [MEM_DEPTH];

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
      shreg     <= '0;
      shout     <= '0;
      rw        <= 1'b0;
      mack      <= 1'b1;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_stb    <= 1'b0;
      wr_adr    <= '0;
      wr_dat    <= '0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      byte_done <= byte_done_n;
      shreg     <= shreg_n;
      shout     <= shout_n;
      rw        <= rw_n;
      mack      <= mack_n;
      ptr       <= ptr_n;
      sda_oe    <= sda_oe_n;
      busy      <= busy_n;
      wr_stb    <= wr_stb_n;
      wr_adr    <= wr_adr_n;
      wr_dat    <= wr_dat_n;
    end
  end

  // Register file is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[ptr] <= shreg;
  end

  // Received bytes are evaluated on the SCL fall after their 8th bit, which is where ACK is driven.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    byte_done_n = byte_done;
    shreg_n     = shreg;
    shout_n     = shout;
    rw_n        = rw;
    mack_n      = mack;
    ptr_n       = ptr;
    sda_oe_n    = sda_oe;
    busy_n      = busy;
    wr_stb_n    = 1'b0;
    wr_adr_n    = wr_adr;
    wr_dat_n    = wr_dat;
    mem_we_c    = 1'b0;

    if (start_c) begin
      state_n     = ADDR;
      bit_cnt_n   = '0;
      byte_done_n = 1'b0;
      sda_oe_n    = 1'b0;
      busy_n      = 1'b1;
    end else if (stop_c) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      if (scl_rise_c && !byte_done && (state == ADDR || state == MADR || state == WDATA)) begin
        shreg_n   = {shreg[6:0], filt[0]};
        bit_cnt_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) byte_done_n = 1'b1;
      end
      if (scl_rise_c && state == RDATA_ACK) mack_n = filt[0];

      if (scl_fall_c) begin
        case (state)
          ADDR: if (byte_done) begin
            byte_done_n = 1'b0;
            if (shreg[7:1] == I2C_ADR) begin
              rw_n     = shreg[0];
              sda_oe_n = 1'b1;
              state_n  = ADDR_ACK;
            end else begin
              state_n = IGNORE;
            end
          end
          ADDR_ACK: begin
            bit_cnt_n = '0;
            if (rw) begin
              shout_n  = mem[ptr];
              sda_oe_n = ~mem[ptr][7];
              state_n  = RDATA;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = MADR;
            end
          end
          MADR: if (byte_done) begin
            byte_done_n = 1'b0;
            if (32'(shreg) < MEM_DEPTH) begin
              ptr_n    = shreg[AW-1:0];
              sda_oe_n = 1'b1;
              state_n  = MADR_ACK;
            end else begin
              state_n = IGNORE;
            end
          end
          MADR_ACK: begin
            sda_oe_n = 1'b0;
            state_n  = WDATA;
          end
          WDATA: if (byte_done) begin
            byte_done_n = 1'b0;
            mem_we_c    = 1'b1;
            wr_stb_n    = 1'b1;
            wr_adr_n    = ptr;
            wr_dat_n    = shreg;
            ptr_n       = ptr + AW'(1);
            sda_oe_n    = 1'b1;
            state_n     = WDATA_ACK;
          end
          WDATA_ACK: begin
            sda_oe_n = 1'b0;
            state_n  = WDATA;
          end
          RDATA: begin
            if (bit_cnt == 3'd7) begin
              sda_oe_n = 1'b0;
              ptr_n    = ptr + AW'(1);
              state_n  = RDATA_ACK;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
              shout_n   = {shout[6:0], 1'b0};
              sda_oe_n  = ~shout[6];
            end
          end
          RDATA_ACK: begin
            if (!mack) begin
              shout_n   = mem[ptr];
              sda_oe_n  = ~mem[ptr][7];
              bit_cnt_n = '0;
              state_n   = RDATA;
            end else begin
              state_n = IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Bench for i2c_slave_mem: bit-banged I2C master with a register-file/pointer reference model.
`timescale 1ns/1ps
module tb_i2c_slave_mem;

  localparam int unsigned Q     = 10;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0, nReset = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
  logic       sda_oe, busy, wr_stb, sda_line;
  logic [3:0] wr_adr;
  logic [7:0] wr_dat;

  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_slave_mem #(.I2C_ADR(7'h10), .MEM_DEPTH(16), .AW(4), .FILT(3)) dut (
    .clk(clk), .nReset(nReset), .scl_i(scl_m), .sda_i(sda_line),
    .sda_oe(sda_oe), .busy(busy), .wr_stb(wr_stb), .wr_adr(wr_adr), .wr_dat(wr_dat)
  );

  int          n_chk = 0, n_pass = 0, n_fail = 0;
  logic [7:0]  mem_m [DEPTH];
  int          ptr_m = 0;
  logic [11:0] exp_q [$], got_q [$];
  logic [7:0]  wbuf [$];

  always @(negedge clk) if (wr_stb) got_q.push_back({wr_adr, wr_dat});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_bit(input logic v, output logic s);
    wq(Q); sda_m = v; wq(Q); scl_m = 1'b1; wq(Q); s = sda_line; wq(Q); scl_m = 1'b0;
  endtask

  task automatic start_cond();
    wq(Q); sda_m = 1'b1; wq(Q); scl_m = 1'b1; wq(Q); sda_m = 1'b0; wq(Q); scl_m = 1'b0;
  endtask

  task automatic stop_cond();
    wq(Q); sda_m = 1'b0; wq(Q); scl_m = 1'b1; wq(Q); sda_m = 1'b1; wq(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic last, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    clk_bit(last, s);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, " wr_stb count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk({tag, " wr adr/dat"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  // Write transaction of wbuf at pointer p; glitch adds a 1-clk SCL pulse just after START.
  task automatic do_write(input logic [7:0] p, input bit glitch, input string tag);
    logic a;
    bit   ok;
    start_cond();
    if (glitch) begin
      wq(Q); scl_m = 1'b1; wq(1); scl_m = 1'b0;
    end
    send_byte({7'h10, 1'b0}, a);
    chk({tag, " adr ack"}, 32'(a), 0);
    chk({tag, " busy"}, 32'(busy), 1);
    send_byte(p, a);
    ok = (int'(p) < DEPTH);
    chk({tag, " ptr ack"}, 32'(a), ok ? 0 : 1);
    if (ok) ptr_m = int'(p);
    foreach (wbuf[i]) begin
      send_byte(wbuf[i], a);
      chk({tag, " data ack"}, 32'(a), ok ? 0 : 1);
      if (ok) begin
        mem_m[ptr_m] = wbuf[i];
        exp_q.push_back({4'(ptr_m), wbuf[i]});
        ptr_m = (ptr_m + 1) % DEPTH;
      end
    end
    stop_cond();
    chk({tag, " busy after stop"}, 32'(busy), 0);
    check_writes(tag);
  endtask

  // Read n bytes; if set_ptr, first write pointer p then repeated START.
  task automatic do_read(input bit set_ptr, input logic [7:0] p, input int n, input string tag);
    logic       a;
    logic [7:0] b;
    start_cond();
    if (set_ptr) begin
      send_byte({7'h10, 1'b0}, a);
      chk({tag, " adr ack"}, 32'(a), 0);
      send_byte(p, a);
      chk({tag, " ptr ack"}, 32'(a), (int'(p) < DEPTH) ? 0 : 1);
      if (int'(p) < DEPTH) ptr_m = int'(p);
      start_cond();
    end
    send_byte({7'h10, 1'b1}, a);
    chk({tag, " rd adr ack"}, 32'(a), 0);
    for (int k = 0; k < n; k++) begin
      read_byte(k == n - 1, b);
      chk({tag, " rd data"}, 32'(b), 32'(mem_m[ptr_m]));
      ptr_m = (ptr_m + 1) % DEPTH;
    end
    chk({tag, " released after nack"}, 32'(sda_oe), 0);
    stop_cond();
    chk({tag, " busy after stop"}, 32'(busy), 0);
    check_writes(tag);
  endtask

  initial begin
    logic a, s;
    int   kind, len;

    wq(3);
    chk("rst sda_oe", 32'(sda_oe), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst wr_stb", 32'(wr_stb), 0);
    chk("rst wr_adr", 32'(wr_adr), 0);
    chk("rst wr_dat", 32'(wr_dat), 0);
    nReset = 1'b1;
    wq(4 * Q);

    wbuf = '{8'hA5, 8'h5A};
    do_write(8'h03, 1'b0, "wr3");
    do_read(1'b1, 8'h03, 2, "rd3");

    start_cond();
    send_byte({7'h11, 1'b0}, a);
    chk("wrong adr nack", 32'(a), 1);
    send_byte(8'h01, a);
    chk("wrong adr data nack", 32'(a), 1);
    stop_cond();
    chk("wrong adr busy", 32'(busy), 0);
    check_writes("wrong adr");

    wbuf = '{8'h77, 8'h88};
    do_write(8'h10, 1'b0, "oor ptr");

    wbuf = '{8'h11, 8'h22};
    do_write(8'h0F, 1'b0, "wrap wr");
    do_read(1'b1, 8'h0F, 2, "wrap rd");

    wbuf = '{8'hC3};
    do_write(8'h05, 1'b1, "glitch wr");
    do_read(1'b1, 8'h05, 1, "glitch rd");

    // Reset while the slave is driving the address ACK.
    start_cond();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] adw;
      adw = {7'h10, 1'b0};
      clk_bit(adw[i], s);
    end
    wq(Q); sda_m = 1'b1; wq(Q); scl_m = 1'b1; wq(Q);
    chk("ack before reset", 32'(sda_oe), 1);
    nReset = 1'b0;
    #1;
    chk("sda_oe in reset", 32'(sda_oe), 0);
    chk("busy in reset", 32'(busy), 0);
    wq(2);
    nReset = 1'b1;
    wq(Q); scl_m = 1'b0;
    stop_cond();
    ptr_m = 0;
    do_read(1'b0, 8'h00, 1, "post rst rd");

    wbuf.delete();
    for (int i = 0; i < 18; i++) wbuf.push_back(8'($urandom));
    do_write(8'h00, 1'b0, "fill");

    for (int it = 0; it < 12; it++) begin
      kind = int'($urandom_range(0, 2));
      len  = int'($urandom_range(1, 3));
      if (kind == 0) begin
        wbuf.delete();
        for (int i = 0; i < len; i++) wbuf.push_back(8'($urandom));
        do_write(8'($urandom_range(0, 19)), 1'b0, "rnd wr");
      end else begin
        do_read(kind == 1, 8'($urandom_range(0, 19)), len, "rnd rd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
